// File: rtl/risc_core_p.sv
// risc_core_p - multicycle CPU core with register file, ALU and Z/C flags.
//
// Purpose: fetches 16-bit instructions from a unified instruction/data
// memory over a req/ack handshake. It executes them with a hardwired
// FSM (FETCH -> EXEC -> optional MEM_RD/MEM_WR -> FETCH) and drives a
// registered GPIO port.
//
// Ports:
//   clk        rising-edge clock
//   rst_CPU    synchronous active-high reset
//   mem_req    memory request, held until mem_ack
//   mem_we     1 = write, 0 = read (valid while mem_req)
//   mem_addr   word address (valid while mem_req)
//   mem_wdata  write data (valid while mem_req && mem_we)
//   mem_rdata  read data (valid in the mem_ack cycle)
//   mem_ack    transaction complete (only honoured while mem_req=1)
//   gpio_out   registered GPIO output
//   halted     core is in HALT
//
// Build option: define RISC_MUL_EN to turn opcode 0 into an unsigned
// multiply. Without it, opcode 0 is NOP and no multiplier is built.

module risc_core_p #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 13,
  parameter int REG_N    = 16,
  parameter int GPIO_W   = 4,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_CPU,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              halted
);

  localparam logic [3:0] OP_NOP = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4, OP_XOR = 4'h5, OP_SHL = 4'h6, OP_LDI = 4'h7;
  localparam logic [3:0] OP_LD  = 4'h8, OP_ST  = 4'h9, OP_JZ  = 4'hA, OP_JC  = 4'hB;
  localparam logic [3:0] OP_JMP = 4'hC, OP_CMP = 4'hD, OP_OUT = 4'hE, OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_EXEC   = 3'd1,
    ST_MEM_RD = 3'd2,
    ST_MEM_WR = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  state_t              state_r;
  logic [ADDR_W-1:0]   pc_r;
  logic [15:0]         ir_r;
  logic                z_r;
  logic                c_r;
  logic [DATA_W-1:0]   regs_r [0:REG_N-1];
  logic                mem_req_r;
  logic                mem_we_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic [DATA_W-1:0]   mem_wdata_r;
  logic [GPIO_W-1:0]   gpio_r;
  logic                halted_r;

  // r0 and indices beyond the register file are not real storage.
  function automatic logic idx_ok(input logic [3:0] idx);
    return (idx != 4'd0) && (int'(idx) < REG_N);
  endfunction

  logic [3:0]        op_s, rd_idx_s, ra_idx_s, rb_idx_s;
  logic [DATA_W-1:0] rd_val_s, ra_val_s, rb_val_s;
  logic              rd_ok_s;
  logic [DATA_W:0]   sum_s, diff_s, shl_s;
  logic [DATA_W-1:0] alu_res_s;
  logic              alu_c_s, alu_z_s, alu_wr_s, alu_flag_s;
`ifdef RISC_MUL_EN
  logic [2*DATA_W-1:0] prod_s;
`endif

  assign op_s     = ir_r[15:12];
  assign rd_idx_s = ir_r[11:8];
  assign ra_idx_s = ir_r[7:4];
  assign rb_idx_s = ir_r[3:0];
  assign rd_ok_s  = idx_ok(rd_idx_s);
  assign rd_val_s = idx_ok(rd_idx_s) ? regs_r[rd_idx_s] : {DATA_W{1'b0}};
  assign ra_val_s = idx_ok(ra_idx_s) ? regs_r[ra_idx_s] : {DATA_W{1'b0}};
  assign rb_val_s = idx_ok(rb_idx_s) ? regs_r[rb_idx_s] : {DATA_W{1'b0}};

  // One extra MSB catches ADD carry, SUB borrow and the last SHL bit shifted out.
  assign sum_s  = {1'b0, ra_val_s} + {1'b0, rb_val_s};
  assign diff_s = {1'b0, ra_val_s} - {1'b0, rb_val_s};
  assign shl_s  = {1'b0, ra_val_s} << ir_r[3:0];
`ifdef RISC_MUL_EN
  assign prod_s = ra_val_s * rb_val_s;
`endif

  // ALU: result, carry, writeback enable and flag-update enable for the current IR.
  always_comb begin
    alu_res_s  = {DATA_W{1'b0}};
    alu_c_s    = 1'b0;
    alu_wr_s   = 1'b0;
    alu_flag_s = 1'b0;
    case (op_s)
`ifdef RISC_MUL_EN
      OP_NOP: begin
        alu_res_s  = prod_s[DATA_W-1:0];
        alu_c_s    = |prod_s[2*DATA_W-1:DATA_W];
        alu_wr_s   = 1'b1;
        alu_flag_s = 1'b1;
      end
`endif
      OP_ADD: begin
        alu_res_s  = sum_s[DATA_W-1:0];
        alu_c_s    = sum_s[DATA_W];
        alu_wr_s   = 1'b1;
        alu_flag_s = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        alu_res_s  = diff_s[DATA_W-1:0];
        alu_c_s    = diff_s[DATA_W];
        alu_wr_s   = (op_s == OP_SUB);
        alu_flag_s = 1'b1;
      end
      OP_AND: begin
        alu_res_s  = ra_val_s & rb_val_s;
        alu_wr_s   = 1'b1;
        alu_flag_s = 1'b1;
      end
      OP_OR: begin
        alu_res_s  = ra_val_s | rb_val_s;
        alu_wr_s   = 1'b1;
        alu_flag_s = 1'b1;
      end
      OP_XOR: begin
        alu_res_s  = ra_val_s ^ rb_val_s;
        alu_wr_s   = 1'b1;
        alu_flag_s = 1'b1;
      end
      OP_SHL: begin
        alu_res_s  = shl_s[DATA_W-1:0];
        alu_c_s    = shl_s[DATA_W];
        alu_wr_s   = 1'b1;
        alu_flag_s = 1'b1;
      end
      OP_LDI: begin
        alu_res_s  = {{(DATA_W-8){1'b0}}, ir_r[7:0]};
        alu_wr_s   = 1'b1;
      end
      default: begin
        alu_res_s  = {DATA_W{1'b0}};
        alu_c_s    = 1'b0;
        alu_wr_s   = 1'b0;
        alu_flag_s = 1'b0;
      end
    endcase
  end

  assign alu_z_s = (alu_res_s == {DATA_W{1'b0}});

  // Main FSM: fetch/execute sequencing, register file, flags and memory handshake.
  always_ff @(posedge clk) begin
    if (rst_CPU) begin
      state_r     <= ST_FETCH;
      pc_r        <= ADDR_W'(RESET_PC);
      ir_r        <= 16'h0000;
      z_r         <= 1'b0;
      c_r         <= 1'b0;
      for (int i = 0; i < REG_N; i++) regs_r[i] <= {DATA_W{1'b0}};
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
      gpio_r      <= {GPIO_W{1'b0}};
      halted_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_FETCH: begin
          // Ack only counts once our request is already visible on the bus.
          if (mem_req_r && mem_ack) begin
            ir_r      <= mem_rdata[15:0];
            pc_r      <= pc_r + ADDR_W'(1);
            mem_req_r <= 1'b0;
            state_r   <= ST_EXEC;
          end else begin
            mem_req_r  <= 1'b1;
            mem_we_r   <= 1'b0;
            mem_addr_r <= pc_r;
          end
        end
        ST_EXEC: begin
          state_r <= ST_FETCH;
          if (alu_flag_s) begin
            z_r <= alu_z_s;
            c_r <= alu_c_s;
          end
          if (alu_wr_s && rd_ok_s) regs_r[rd_idx_s] <= alu_res_s;
          case (op_s)
            OP_LD:  state_r <= ST_MEM_RD;
            OP_ST:  state_r <= ST_MEM_WR;
            OP_JZ:  if (z_r) pc_r <= ra_val_s[ADDR_W-1:0];
            OP_JC:  if (c_r) pc_r <= ra_val_s[ADDR_W-1:0];
            OP_JMP: pc_r <= ra_val_s[ADDR_W-1:0];
            OP_OUT: gpio_r <= rd_val_s[GPIO_W-1:0];
            OP_HLT: begin
              state_r  <= ST_HALT;
              halted_r <= 1'b1;
            end
            default: state_r <= ST_FETCH;
          endcase
        end
        ST_MEM_RD: begin
          if (mem_req_r && mem_ack) begin
            if (rd_ok_s) regs_r[rd_idx_s] <= mem_rdata;
            mem_req_r <= 1'b0;
            state_r   <= ST_FETCH;
          end else begin
            mem_req_r  <= 1'b1;
            mem_we_r   <= 1'b0;
            mem_addr_r <= ra_val_s[ADDR_W-1:0];
          end
        end
        ST_MEM_WR: begin
          if (mem_req_r && mem_ack) begin
            mem_req_r <= 1'b0;
            state_r   <= ST_FETCH;
          end else begin
            mem_req_r   <= 1'b1;
            mem_we_r    <= 1'b1;
            mem_addr_r  <= ra_val_s[ADDR_W-1:0];
            mem_wdata_r <= rd_val_s;
          end
        end
        ST_HALT: begin
          state_r   <= ST_HALT;
          mem_req_r <= 1'b0;
          halted_r  <= 1'b1;
        end
        default: state_r <= ST_FETCH;
      endcase
    end
  end

  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign gpio_out  = gpio_r;
  assign halted    = halted_r;

endmodule

// File: tb/tb_risc_core_p.sv
// tb_risc_core_p - directed self-checking bench for risc_core_p.
// A behavioural memory model with a programmable ack delay serves the core.
// Small hand-assembled programs exercise it, and each result is compared
// against a hand-computed constant.

module tb_risc_core_p;

  logic        clk;
  logic        rst;
  logic        mem_req, mem_we, mem_ack;
  logic [12:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic [3:0]  gpio_out;
  logic        halted;

  logic [15:0] mem [0:8191];
  logic [3:0]  wait_cnt;
  int          ack_delay;
  logic        stray_ack;

  int n_chk;
  int n_pass;

  risc_core_p dut (
    .clk       (clk),
    .rst_CPU   (rst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .gpio_out  (gpio_out),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: ack after ack_delay wait cycles of a held request.
  assign mem_ack   = stray_ack | (mem_req && (int'(wait_cnt) == ack_delay));
  assign mem_rdata = mem[mem_addr];

  // Memory model state: wait counter and write port.
  always @(posedge clk) begin
    if (rst || !mem_req || mem_ack) wait_cnt <= 4'd0;
    else                            wait_cnt <= wait_cnt + 4'd1;
    if (!rst && mem_req && mem_we && mem_ack) mem[mem_addr] = mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 8192; i++) mem[i] = 16'h0000;
  endtask

  task automatic restart();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_halt(input int bound, output int cyc);
    cyc = 0;
    while (cyc < bound && !halted) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  int          cyc;
  int          wr_cyc;
  logic        stable;
  logic        found;
  logic [12:0] a0;
  logic [15:0] d0;

  initial begin
    n_chk = 0; n_pass = 0;
    rst = 1'b1; stray_ack = 1'b0; ack_delay = 0;

    // Program 1: LDI r1,5; LDI r2,3; ADD r3=r1+r2; OUT r3; HLT
    clear_mem();
    mem[0] = 16'h7105; mem[1] = 16'h7203; mem[2] = 16'h1312;
    mem[3] = 16'hE300; mem[4] = 16'hF000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req",    {31'h0, mem_req}, 32'h0);
    chk("rst_we",     {31'h0, mem_we}, 32'h0);
    chk("rst_addr",   {19'h0, mem_addr}, 32'h0);
    chk("rst_wdata",  {16'h0, mem_wdata}, 32'h0);
    chk("rst_gpio",   {28'h0, gpio_out}, 32'h0);
    chk("rst_halted", {31'h0, halted}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    run_halt(100, cyc);
    chk("p1_halted", {31'h0, halted}, 32'h1);
    chk("p1_cycles", cyc, 32'd15);
    chk("p1_gpio",   {28'h0, gpio_out}, 32'h8);
    chk("p1_r3",     {16'h0, dut.regs_r[3]}, 32'h0008);

    // SUB r3 = 3 - 5
    clear_mem();
    mem[0] = 16'h7103; mem[1] = 16'h7205; mem[2] = 16'h2312; mem[3] = 16'hF000;
    restart();
    run_halt(100, cyc);
    chk("sub_r3", {16'h0, dut.regs_r[3]}, 32'hFFFE);
    chk("sub_c",  {31'h0, dut.c_r}, 32'h1);
    chk("sub_z",  {31'h0, dut.z_r}, 32'h0);

    // CMP 5,5 with r3 preset to 0x77
    clear_mem();
    mem[0] = 16'h7105; mem[1] = 16'h7205; mem[2] = 16'h7377;
    mem[3] = 16'hD312; mem[4] = 16'hF000;
    restart();
    run_halt(100, cyc);
    chk("cmp_z",  {31'h0, dut.z_r}, 32'h1);
    chk("cmp_c",  {31'h0, dut.c_r}, 32'h0);
    chk("cmp_r3", {16'h0, dut.regs_r[3]}, 32'h0077);

    // ST r2 -> [0x40], LD r3 <- [0x40], ack delayed 4 cycles
    clear_mem();
    mem[0] = 16'h7140; mem[1] = 16'h72A5; mem[2] = 16'h9210;
    mem[3] = 16'h8310; mem[4] = 16'hF000;
    ack_delay = 4;
    restart();
    wr_cyc = 0; stable = 1'b1; a0 = 13'h0; d0 = 16'h0;
    for (int i = 0; i < 400 && !halted; i++) begin
      @(negedge clk);
      if (mem_req && mem_we) begin
        if (wr_cyc == 0) begin
          a0 = mem_addr;
          d0 = mem_wdata;
        end else if (mem_addr !== a0 || mem_wdata !== d0) begin
          stable = 1'b0;
        end
        wr_cyc++;
      end
    end
    chk("stld_halted", {31'h0, halted}, 32'h1);
    chk("st_req_len",  wr_cyc, 32'd5);
    chk("st_stable",   {31'h0, stable}, 32'h1);
    chk("st_addr",     {19'h0, a0}, 32'h0040);
    chk("st_mem",      {16'h0, mem[64]}, 32'h00A5);
    chk("ld_r3",       {16'h0, dut.regs_r[3]}, 32'h00A5);

    // Reset during a pending fetch, then a stray ack
    clear_mem();
    ack_delay = 8;
    restart();
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (mem_req && mem_addr == 13'h0002) found = 1'b1;
    end
    chk("rm_reached", {31'h0, found}, 32'h1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rm_req_drop", {31'h0, mem_req}, 32'h0);
    chk("rm_addr",     {19'h0, mem_addr}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    chk("rm_stray_req",  {31'h0, mem_req}, 32'h1);
    chk("rm_stray_addr", {19'h0, mem_addr}, 32'h0);
    chk("rm_stray_we",   {31'h0, mem_we}, 32'h0);
    ack_delay = 0;

    // LDI r0 / ST r0, then build 0x1FFF and jump there to test PC wrap
    clear_mem();
    mem[0] = 16'h70FF; mem[1] = 16'h7350; mem[2] = 16'h9030; mem[3] = 16'h71FF;
    mem[4] = 16'h721F; mem[5] = 16'h6228; mem[6] = 16'h4121; mem[7] = 16'hC010;
    mem[80] = 16'hDEAD;
    mem[8191] = 16'h0000;
    restart();
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (mem_req && mem_addr == 13'h1FFF) found = 1'b1;
    end
    chk("wrap_reached", {31'h0, found}, 32'h1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (mem_req && mem_addr != 13'h1FFF) found = 1'b1;
    end
    chk("wrap_next_addr", {19'h0, mem_addr}, 32'h0);
    chk("r0_reads_zero",  {16'h0, mem[80]}, 32'h0);

`ifdef RISC_MUL_EN
    // MUL 0x0100 * 0x0100
    clear_mem();
    mem[0] = 16'h7377; mem[1] = 16'h7101; mem[2] = 16'h6118; mem[3] = 16'h7201;
    mem[4] = 16'h6228; mem[5] = 16'h0312; mem[6] = 16'hF000;
    restart();
    run_halt(100, cyc);
    chk("mul_r3", {16'h0, dut.regs_r[3]}, 32'h0);
    chk("mul_z",  {31'h0, dut.z_r}, 32'h1);
    chk("mul_c",  {31'h0, dut.c_r}, 32'h1);
`else
    // Opcode 0 as NOP leaves registers and flags alone
    clear_mem();
    mem[0] = 16'h7107; mem[1] = 16'h7209; mem[2] = 16'h7377;
    mem[3] = 16'h0312; mem[4] = 16'h0123; mem[5] = 16'hF000;
    restart();
    run_halt(100, cyc);
    chk("nop_r1", {16'h0, dut.regs_r[1]}, 32'h0007);
    chk("nop_r2", {16'h0, dut.regs_r[2]}, 32'h0009);
    chk("nop_r3", {16'h0, dut.regs_r[3]}, 32'h0077);
    chk("nop_z",  {31'h0, dut.z_r}, 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
